// File: rtl/addr_decode_seq_if.sv
// Bus bundle between the SPI address register and the address decoder.
// The master drives chip select, address and strobes; the slave returns the decoded selection.
interface addr_decode_seq_if #(
  parameter int ADDR_W = 7,
  parameter int CH_W   = 3,
  parameter int REG_W  = 3
);
  logic              csb;
  logic [ADDR_W-1:0] addr;
  logic              addr_load;
  logic              incr;
  logic              busy;
  logic              sel_valid;
  logic              out_of_range;
  logic [CH_W-1:0]   ch_sel;
  logic [REG_W-1:0]  reg_sel;

  modport master (
    output csb, addr, addr_load, incr,
    input  busy, sel_valid, out_of_range, ch_sel, reg_sel
  );

  modport slave (
    input  csb, addr, addr_load, incr,
    output busy, sel_valid, out_of_range, ch_sel, reg_sel
  );
endinterface

// File: rtl/addr_decode_seq.sv
// Readout address to channel/register decoder using an iterative subtract divider with burst increment.
// Optional macro BURST_WRAP_EN: incr past the last register of the last channel wraps to channel 0, register 0.
module addr_decode_seq #(
  parameter int ADDR_W      = 7,
  parameter int BASE_ADDR   = 11,
  parameter int NUM_CH      = 8,
  parameter int REGS_PER_CH = 7,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter int REG_W       = $clog2(REGS_PER_CH + 1)
) (
  input logic              sclk,
  input logic              rstn,
  addr_decode_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIVIDE, VALID, INVALID} state_t;

  localparam logic [31:0]       BASE_WIDE  = 32'(BASE_ADDR);
  localparam logic [31:0]       LIMIT_WIDE = 32'(BASE_ADDR + NUM_CH * REGS_PER_CH);
  localparam logic [ADDR_W-1:0] REGS_STEP  = ADDR_W'(REGS_PER_CH);
  localparam logic [REG_W-1:0]  LAST_REG   = REG_W'(REGS_PER_CH - 1);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [REG_W-1:0]  REG_NONE   = '1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] rem_reg, rem_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [REG_W-1:0]  rsel_reg, rsel_next;
  logic              busy_reg, busy_next;
  logic              valid_reg, valid_next;
  logic              oor_reg, oor_next;
  logic [31:0]       addr_wide;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      ch_reg    <= '0;
      rsel_reg  <= REG_NONE;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      oor_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      ch_reg    <= ch_next;
      rsel_reg  <= rsel_next;
      busy_reg  <= busy_next;
      valid_reg <= valid_next;
      oor_reg   <= oor_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    ch_next    = ch_reg;
    rsel_next  = rsel_reg;
    busy_next  = busy_reg;
    valid_next = valid_reg;
    oor_next   = oor_reg;
    addr_wide  = 32'(bus.addr);

    // Deselect dominates everything: the SPI transaction is over.
    if (bus.csb) begin
      state_next = IDLE;
      rem_next   = '0;
      ch_next    = '0;
      rsel_next  = REG_NONE;
      busy_next  = 1'b0;
      valid_next = 1'b0;
      oor_next   = 1'b0;
    end else if (bus.addr_load) begin
      ch_next    = '0;
      rsel_next  = REG_NONE;
      valid_next = 1'b0;
      if (addr_wide < BASE_WIDE || addr_wide >= LIMIT_WIDE) begin
        state_next = INVALID;
        busy_next  = 1'b0;
        oor_next   = 1'b1;
      end else begin
        state_next = DIVIDE;
        rem_next   = ADDR_W'(addr_wide - BASE_WIDE);
        busy_next  = 1'b1;
        oor_next   = 1'b0;
      end
    end else begin
      case (state_reg)
        DIVIDE: begin
          // One subtraction per edge; the quotient accumulates directly in ch_sel.
          if (rem_reg >= REGS_STEP) begin
            rem_next = rem_reg - REGS_STEP;
            ch_next  = ch_reg + CH_W'(1);
          end else begin
            rsel_next  = rem_reg[REG_W-1:0];
            busy_next  = 1'b0;
            valid_next = 1'b1;
            state_next = VALID;
          end
        end
        VALID: begin
          if (bus.incr) begin
            if (rsel_reg < LAST_REG) begin
              rsel_next = rsel_reg + REG_W'(1);
            end else if (ch_reg < LAST_CH) begin
              rsel_next = '0;
              ch_next   = ch_reg + CH_W'(1);
            end else begin
`ifdef BURST_WRAP_EN
              rsel_next = '0;
              ch_next   = '0;
`else
              state_next = INVALID;
              rsel_next  = REG_NONE;
              valid_next = 1'b0;
              oor_next   = 1'b1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy_reg;
  assign bus.sel_valid    = valid_reg;
  assign bus.out_of_range = oor_reg;
  assign bus.ch_sel       = ch_reg;
  assign bus.reg_sel      = rsel_reg;

endmodule

// File: doc/addr_decode_seq.md
Name: addr_decode_seq

Overview:
- Parametrised, sequential successor to the fixed SPI readout address-to-channel decoder.
- Converts a readout address into a channel index and a per-channel register index using an iterative subtract divider, with no modulo operator and no lookup table.
- Supports burst auto-increment across registers and channels while csb is low.
- Sits between the SPI address register and the per-channel readout muxes.

Parameters:
- ADDR_W, 7, address width.
- BASE_ADDR, 11, first readout address (channel 0, register 0).
- NUM_CH, 8, number of channels.
- REGS_PER_CH, 7, readout registers per channel.
- CH_W, $clog2(NUM_CH), channel index width (derived).
- REG_W, $clog2(REGS_PER_CH+1), register index width (derived); all-ones is never a legal index.

Ports:
- sclk  input  1  SPI-domain clock.
- rstn  input  1  asynchronous active-low reset.
- csb  input  1  SPI chip select, active low; high aborts and clears.
- addr  input  ADDR_W  address, sampled on addr_load.
- addr_load  input  1  single-cycle pulse: start a decode of addr.
- incr  input  1  single-cycle pulse: advance to the next register.
- busy  output  1  decode in progress.
- sel_valid  output  1  ch_sel and reg_sel are valid.
- out_of_range  output  1  last decoded or advanced address is outside the readout map.
- ch_sel  output  CH_W  channel index.
- reg_sel  output  REG_W  register index; all-ones when invalid.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE, ch_sel=0, reg_sel=all-ones, sel_valid=0, busy=0, out_of_range=0. Reset mid-decode discards the decode.
- States: IDLE, DIVIDE, VALID, INVALID.
- csb high: synchronous clear on the next sclk edge. Outputs go to their reset values and the state returns to IDLE. csb high has priority over addr_load and incr. While csb is high, addr_load and incr are ignored.
- addr_load (csb low, any state):
  - Range check: if addr < BASE_ADDR or addr >= BASE_ADDR + NUM_CH*REGS_PER_CH, go to INVALID next edge with out_of_range=1, sel_valid=0, reg_sel=all-ones, ch_sel=0.
  - Otherwise: rem <= addr - BASE_ADDR (ADDR_W bits), ch_sel <= 0, busy <= 1, sel_valid <= 0, state DIVIDE.
  - addr_load during DIVIDE restarts the decode.
  - addr_load together with incr: the load wins and incr is dropped.
- DIVIDE, each edge:
  - If rem >= REGS_PER_CH: rem <= rem - REGS_PER_CH and ch_sel <= ch_sel + 1.
  - Else: reg_sel <= rem[REG_W-1:0], busy <= 0, sel_valid <= 1, state VALID.
- Latency: sel_valid rises ch+1 edges after the load edge, where ch is the final channel index. Worst case is NUM_CH edges.
- incr in DIVIDE or IDLE: ignored. incr in INVALID: ignored; state stays INVALID.
- incr in VALID:
  - reg_sel < REGS_PER_CH-1: reg_sel + 1.
  - reg_sel = REGS_PER_CH-1 and ch_sel < NUM_CH-1: reg_sel <= 0, ch_sel + 1.
  - reg_sel = REGS_PER_CH-1 and ch_sel = NUM_CH-1: go to INVALID with out_of_range=1, sel_valid=0, reg_sel=all-ones, ch_sel held.
  - sel_valid stays high across legal increments; the new indices appear one edge after incr.
- busy and sel_valid are never high together.
- All outputs are registered.

Optional Feature:
- Macro BURST_WRAP_EN.
- Defined: incr at the last register of the last channel wraps to ch_sel=0, reg_sel=0, and sel_valid stays 1. out_of_range is not set by this wrap.
- Undefined: the same incr goes to INVALID as described above.
- The macro does not affect range checking on addr_load.

Test Plan:
- Reset, then csb=0, load addr=11: sel_valid rises 1 edge after the load edge with ch_sel=0, reg_sel=0; busy is high in the intervening cycle.
- Load addr=17: ch_sel=0, reg_sel=6. Load addr=18: ch_sel=1, reg_sel=0 after 2 edges. Load addr=66: ch_sel=7, reg_sel=6 after 8 edges.
- Load addr=10, addr=67 and addr=127 in turn: each gives INVALID next edge with out_of_range=1, reg_sel=3'b111, sel_valid=0.
- Load addr=59 (ch 6, reg 6), then incr: ch_sel=7, reg_sel=0. At ch 7 reg 6, incr gives INVALID, out_of_range=1 without the macro; with BURST_WRAP_EN it gives ch 0, reg 0 and sel_valid=1.
- Load addr=60, then raise csb at the 3rd DIVIDE cycle: outputs go to reset values next edge. Load together with incr in VALID: the load wins.
- Assert rstn=0 asynchronously mid-DIVIDE: outputs clear immediately without waiting for sclk. A following load of addr=25 decodes to ch 2, reg 0.
